// File: rtl/hpdl1414_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hpdl1414_write_ctrl
// Purpose  : Write controller for an HPDL1414 4-digit alphanumeric display.
//            Bytes from the UART receive path are buffered in a small FIFO,
//            decoded into printable characters or control codes, and written
//            to the display through a timed setup / WR-strobe / hold sequence.
//            The block owns the cursor, the clear-screen sequence and the
//            sticky overflow flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1  system clock
//   rst_n      in   1  synchronous reset, active-low
//   rx_data    in   8  received byte, sampled when rx_valid=1
//   rx_valid   in   1  one-cycle strobe marking a received byte
//   disp_addr  out  2  display digit address A1:A0
//   disp_data  out  7  display data D6:D0
//   disp_wr_n  out  1  display write strobe, active-low
//   busy       out  1  FSM not idle or FIFO non-empty
//   overflow   out  1  sticky: a byte was dropped on a full FIFO
//   cursor     out  2  next digit to be written
// ----------------------------------------------------------------------------
// Parameters
//   FIFO_DEPTH    byte buffer depth (power of 2, >= 2)
//   SETUP_CYCLES  address/data setup before WR falls (1..255)
//   PULSE_CYCLES  WR low time (1..255)
//   HOLD_CYCLES   address/data hold after WR rises (1..255)
// ----------------------------------------------------------------------------
// Build option
//   HPDL_LOWERCASE_FOLD_EN  when defined, bytes 0x60..0x7F are folded to
//                           0x40..0x5F and written as printable characters;
//                           otherwise they are discarded.
// ============================================================================

module hpdl1414_write_ctrl #(
   parameter int FIFO_DEPTH   = 4,
   parameter int SETUP_CYCLES = 2,
   parameter int PULSE_CYCLES = 4,
   parameter int HOLD_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [1:0] disp_addr,
   output logic [6:0] disp_data,
   output logic       disp_wr_n,
   output logic       busy,
   output logic       overflow,
   output logic [1:0] cursor
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
   localparam logic [7:0]    SETUP_LOAD = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0]    PULSE_LOAD = 8'(PULSE_CYCLES - 1);
   localparam logic [7:0]    HOLD_LOAD  = 8'(HOLD_CYCLES - 1);

   localparam logic [7:0]    CHAR_CR    = 8'h0D;
   localparam logic [7:0]    CHAR_FF    = 8'h0C;
   localparam logic [7:0]    CHAR_BS    = 8'h08;
   localparam logic [6:0]    CHAR_SPACE = 7'h20;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_SETUP  = 3'd2,
      S_STROBE = 3'd3,
      S_HOLD   = 3'd4
   } state_t;

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   state_t           state;
   state_t           state_nxt;

   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    fifo_count;
   logic [CW-1:0]    fifo_count_nxt;
   logic             fifo_empty;
   logic             fifo_full;
   logic             pop;
   logic             push;
   logic             drop;

   logic [7:0]       dec_byte;
   logic             is_print;
   logic [6:0]       print_char;

   logic [7:0]       cnt;
   logic [7:0]       cnt_nxt;
   logic [1:0]       addr_nxt;
   logic [6:0]       data_nxt;
   logic [1:0]       cursor_nxt;
   logic [1:0]       clr_idx;
   logic [1:0]       clr_idx_nxt;
   logic             clr_active;
   logic             clr_active_nxt;
   logic             wr_n_nxt;
   logic             busy_nxt;

   // ------------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------------
   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == DEPTH_C);

   // The FSM only takes a byte when it is idle, so a pop is fully determined
   // by the current state and the FIFO occupancy.
   assign pop  = (state == S_IDLE) && !fifo_empty;

   // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
   assign push = rx_valid && (!fifo_full || pop);
   assign drop = rx_valid && !push;

   always_comb begin
      fifo_count_nxt = fifo_count;
      case ({push, pop})
         2'b10:   fifo_count_nxt = fifo_count + CW'(1);
         2'b01:   fifo_count_nxt = fifo_count - CW'(1);
         default: fifo_count_nxt = fifo_count;
      endcase
   end

   // Pointer width equals log2(depth), so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
         dec_byte   <= 8'h00;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= rx_data;
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) begin
            dec_byte <= fifo_mem[rd_ptr];
            rd_ptr   <= rd_ptr + AW'(1);
         end
         fifo_count <= fifo_count_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Character classification of the byte held in the decode register
   // ------------------------------------------------------------------------
   always_comb begin
      is_print   = 1'b0;
      print_char = dec_byte[6:0];
      if ((dec_byte >= 8'h20) && (dec_byte <= 8'h5F)) begin
         is_print = 1'b1;
      end
`ifdef HPDL_LOWERCASE_FOLD_EN
      else if ((dec_byte >= 8'h60) && (dec_byte <= 8'h7F)) begin
         // Clearing bit 5 maps lower case onto the upper-case glyph set.
         is_print   = 1'b1;
         print_char = {dec_byte[6], 1'b0, dec_byte[4:0]};
      end
`endif
   end

   // ------------------------------------------------------------------------
   // FSM: next-state and next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = (cnt != 8'd0) ? (cnt - 8'd1) : cnt;
      addr_nxt       = disp_addr;
      data_nxt       = disp_data;
      cursor_nxt     = cursor;
      clr_idx_nxt    = clr_idx;
      clr_active_nxt = clr_active;

      case (state)
         S_IDLE: begin
            if (pop) begin
               state_nxt = S_DECODE;
            end
         end

         S_DECODE: begin
            if (is_print) begin
               data_nxt       = print_char;
               addr_nxt       = cursor;
               clr_active_nxt = 1'b0;
               cnt_nxt        = SETUP_LOAD;
               state_nxt      = S_SETUP;
            end else if (dec_byte == CHAR_CR) begin
               cursor_nxt = 2'd0;
               state_nxt  = S_IDLE;
            end else if (dec_byte == CHAR_FF) begin
               clr_active_nxt = 1'b1;
               clr_idx_nxt    = 2'd0;
               data_nxt       = CHAR_SPACE;
               addr_nxt       = 2'd0;
               cnt_nxt        = SETUP_LOAD;
               state_nxt      = S_SETUP;
            end else if (dec_byte == CHAR_BS) begin
               cursor_nxt = cursor - 2'd1;
               state_nxt  = S_IDLE;
            end else begin
               state_nxt = S_IDLE;
            end
         end

         S_SETUP: begin
            if (cnt == 8'd0) begin
               cnt_nxt   = PULSE_LOAD;
               state_nxt = S_STROBE;
            end
         end

         S_STROBE: begin
            if (cnt == 8'd0) begin
               cnt_nxt   = HOLD_LOAD;
               state_nxt = S_HOLD;
            end
         end

         S_HOLD: begin
            if (cnt == 8'd0) begin
               if (clr_active) begin
                  if (clr_idx != 2'd3) begin
                     // Next blank digit; data stays at the space character.
                     clr_idx_nxt = clr_idx + 2'd1;
                     addr_nxt    = clr_idx + 2'd1;
                     cnt_nxt     = SETUP_LOAD;
                     state_nxt   = S_SETUP;
                  end else begin
                     clr_active_nxt = 1'b0;
                     cursor_nxt     = 2'd0;
                     state_nxt      = S_IDLE;
                  end
               end else begin
                  cursor_nxt = cursor + 2'd1;
                  state_nxt  = S_IDLE;
               end
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Registered from next-state values so they line up with the state.
      wr_n_nxt = (state_nxt != S_STROBE);
      busy_nxt = (state_nxt != S_IDLE) || (fifo_count_nxt != '0);
   end

   // ------------------------------------------------------------------------
   // FSM: state and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= 8'd0;
         disp_addr  <= 2'd0;
         disp_data  <= CHAR_SPACE;
         disp_wr_n  <= 1'b1;
         busy       <= 1'b0;
         overflow   <= 1'b0;
         cursor     <= 2'd0;
         clr_idx    <= 2'd0;
         clr_active <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         disp_addr  <= addr_nxt;
         disp_data  <= data_nxt;
         disp_wr_n  <= wr_n_nxt;
         busy       <= busy_nxt;
         cursor     <= cursor_nxt;
         clr_idx    <= clr_idx_nxt;
         clr_active <= clr_active_nxt;
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire
